hack_exec_ctrl: RTL
===================

Name: hack_exec_ctrl

Overview:
Multi-cycle execute/control stage of the Hack-style datapath. It sits directly around the 16-bit ALU:
- Upstream of the ALU: decodes each instruction and drives the ALU control bits and the x/y operands.
- Downstream of the ALU: consumes out/zr/ng.
It owns the A register, D register and PC, and produces the data-memory write interface. Instructions arrive over a valid/ready handshake from the fetch unit.

Parameters:
PC_W, 15, width of pc output and PC register
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  fetch presents an instruction
instr  in  16  instruction word
instr_ready  out  1  stage can accept an instruction
in_m  in  16  data-memory read value at address_m (valid in EXEC)
alu_c  out  6  ALU control bits c1..c6 (zx,nx,zy,ny,f,no); alu_c[5]=c1
alu_x  out  16  ALU x operand (D register)
alu_y  out  16  ALU y operand (A register or in_m)
alu_out  in  16  ALU result (combinational from alu_c/alu_x/alu_y)
alu_zr  in  1  ALU zero flag
alu_ng  in  1  ALU negative flag
out_m  out  16  data to write to memory
write_m  out  1  one-cycle write strobe
address_m  out  15  data-memory address (A[14:0])
pc  out  PC_W  address of next instruction to fetch

Behaviour:
- Reset (async, rst_n=0): state=IDLE, A=0, D=0, PC=RESET_PC, result reg=0, flags reg=0, write_m=0, out_m=0, instr_ready=0 while reset asserted, alu_c=0. Reset mid-EXEC/WB aborts the instruction; no register or memory update.
- FSM states: IDLE -> EXEC -> WB -> IDLE. Throughput: one instruction per 3 cycles.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr into IR and go to EXEC. instr_valid without ready is ignored; fetch must hold the instruction.
- EXEC: instr_ready=0.
  - A-instruction (IR[15]=0): alu_c=0; capture nothing.
  - C-instruction (IR[15]=1): alu_c=IR[11:6]; alu_x=D; alu_y = IR[12] ? in_m : A.
  - End of EXEC: result_reg<=alu_out; zr_reg<=alu_zr; ng_reg<=alu_ng. Go to WB.
- WB, A-instruction: A<=({1'b0,IR[14:0]}); PC<=PC+1.
- WB, C-instruction (d1=IR[5], d2=IR[4], d3=IR[3], j1=IR[2], j2=IR[1], j3=IR[0]):
  - d1: A<=result_reg.
  - d2: D<=result_reg.
  - d3: write_m=1 for this cycle only; out_m=result_reg; address_m = A value before any d1 update.
  - jump = (j1&ng_reg) | (j2&zr_reg) | (j3&~ng_reg&~zr_reg). If jump: PC<=A[PC_W-1:0] using the pre-update A. Else PC<=PC+1.
- C-instruction bits 14:13 are ignored.
- address_m=A[14:0] at all times; out_m holds its last written value; write_m=0 outside WB.
- PC is modulo 2^PC_W: 0x7FFF+1 wraps to 0x0000.
- alu_x/alu_y are driven continuously per the current IR; only the EXEC-cycle ALU result is used.

Optional Feature:
HACK_RETIRE_CNT_EN.
- Defined: adds output port retired (32 bits), reset to 0, incremented by 1 in every WB cycle, wrapping at 2^32.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then A-instruction 16'h1234 accepted -> after WB: A=0x1234, pc=1, write_m never asserted, instr_ready high again 3 cycles after acceptance.
- @5 (16'h0005), then D=A (16'hEC10) -> D=5, pc=2; then D=D+1 (16'hE7D0) -> D=6.
- A=100, D=7, M=D (16'hE308) -> single-cycle write_m=1 with address_m=100, out_m=7; no change to A or D.
- D=0, A=42, D;JEQ (16'hE302) -> pc=42. Repeat with D=3 -> pc=previous+1. D=-1 with D;JLT (16'hE304) -> pc=A.
- AM=M+1 (16'hFDE8) with A=10, in_m=0x00FF -> write_m at address_m=10 with out_m=0x0100; then A=0x0100.
- rst_n pulsed low during EXEC of D=A -> A, D, PC at reset values, no write_m, FSM in IDLE. instr_valid held high while busy -> instruction accepted only once.

Source files
------------

// File: rtl/hack_exec_ctrl.sv
// Hack execute/control stage: decodes instr, drives the external ALU, owns A/D/PC and the data-memory write port.
// Latency: 3 cycles per instruction (IDLE accept -> EXEC -> WB); one instruction per 3 cycles.
// Backpressure: instr_ready only in IDLE; fetch holds instr. `define HACK_RETIRE_CNT_EN adds the retired counter.
module hack_exec_ctrl #(
    parameter int              PC_W     = 15,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [15:0]     instr,
    output logic            instr_ready,
    input  logic [15:0]     in_m,
    output logic [5:0]      alu_c,
    output logic [15:0]     alu_x,
    output logic [15:0]     alu_y,
    input  logic [15:0]     alu_out,
    input  logic            alu_zr,
    input  logic            alu_ng,
    output logic [15:0]     out_m,
    output logic            write_m,
    output logic [14:0]     address_m,
    output logic [PC_W-1:0] pc
`ifdef HACK_RETIRE_CNT_EN
    ,
    output logic [31:0]     retired
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_INC = 1;

    state_t          state, state_nxt;
    logic [15:0]     ir;
    logic [15:0]     a_reg;
    logic [15:0]     d_reg;
    logic [15:0]     result_reg;
    logic [15:0]     out_m_reg;
    logic            zr_reg;
    logic            ng_reg;
    logic [PC_W-1:0] pc_reg;
    logic            is_c;
    logic            accept;
    logic            jump;

    assign is_c   = ir[15];
    assign accept = instr_valid && instr_ready;
    assign jump   = (ir[2] && ng_reg) || (ir[1] && zr_reg) || (ir[0] && !ng_reg && !zr_reg);

    assign alu_x     = d_reg;
    assign alu_y     = (is_c && ir[12]) ? in_m : a_reg;
    assign out_m     = out_m_reg;
    assign address_m = a_reg[14:0];
    assign pc        = pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        alu_c       = 6'd0;
        write_m     = 1'b0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted so fetch never sees a phantom accept.
                instr_ready = rst_n;
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (is_c) begin
                    alu_c = ir[11:6];
                end
                state_nxt = WB;
            end
            WB: begin
                write_m   = is_c && ir[3];
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir         <= 16'd0;
            a_reg      <= 16'd0;
            d_reg      <= 16'd0;
            result_reg <= 16'd0;
            out_m_reg  <= 16'd0;
            zr_reg     <= 1'b0;
            ng_reg     <= 1'b0;
            pc_reg     <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ir <= instr;
                    end
                end
                EXEC: begin
                    result_reg <= alu_out;
                    zr_reg     <= alu_zr;
                    ng_reg     <= alu_ng;
                    // out_m is staged here so it already carries the result during the WB strobe.
                    if (is_c && ir[3]) begin
                        out_m_reg <= alu_out;
                    end
                end
                WB: begin
                    if (!is_c) begin
                        a_reg  <= {1'b0, ir[14:0]};
                        pc_reg <= pc_reg + PC_INC;
                    end else begin
                        if (ir[5]) begin
                            a_reg <= result_reg;
                        end
                        if (ir[4]) begin
                            d_reg <= result_reg;
                        end
                        // Jump target is the A value from before this instruction's d1 write.
                        pc_reg <= jump ? a_reg[PC_W-1:0] : pc_reg + PC_INC;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef HACK_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= 32'd0;
        end else if (state == WB) begin
            retired <= retired + 32'd1;
        end
    end
`endif

endmodule
